// File: rtl/menu_controller.sv
// Pong start-menu sequencer: option selection, blinking cursor overlay,
// game launch pulse and timed game-over hold before returning to the menu.
module menu_controller #(
  parameter int MENU_POSX    = 234,
  parameter int MENU_POSY    = 214,
  parameter int CURSOR_X     = 8,
  parameter int OPT0_Y       = 14,
  parameter int OPT1_Y       = 34,
  parameter int CURSOR_SIZE  = 8,
  parameter int BLINK_FRAMES = 30,
  parameter int OVER_FRAMES  = 120
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_frame_tick,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_select,
  input  logic       i_game_over,
  input  logic [9:0] i_row,
  input  logic [9:0] i_col,
  input  logic [2:0] i_menu_rgb,
  output logic [2:0] o_rgb,
  output logic       o_menu_active,
  output logic       o_game_start,
  output logic       o_two_player
);

  localparam logic [1:0] S_MENU  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_GAME  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int OW = (OVER_FRAMES > 1) ? $clog2(OVER_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [OW-1:0] OVER_LAST  = OW'(OVER_FRAMES - 1);

  // Cursor window bounds, half-open intervals in screen coordinates
  localparam logic [9:0] CX0  = 10'(MENU_POSX + CURSOR_X);
  localparam logic [9:0] CX1  = 10'(MENU_POSX + CURSOR_X + CURSOR_SIZE);
  localparam logic [9:0] RY00 = 10'(MENU_POSY + OPT0_Y);
  localparam logic [9:0] RY01 = 10'(MENU_POSY + OPT0_Y + CURSOR_SIZE);
  localparam logic [9:0] RY10 = 10'(MENU_POSY + OPT1_Y);
  localparam logic [9:0] RY11 = 10'(MENU_POSY + OPT1_Y + CURSOR_SIZE);

  logic [1:0]    r_state;
  logic          r_sel;
  logic          r_two_player;
  logic [2:0]    r_rgb;
  logic          r_blink_on;
  logic [BW-1:0] r_blink_cnt;
  logic [OW-1:0] r_over_cnt;
  logic          r_up_q, r_dn_q, r_sl_q;

  logic       w_up_e, w_dn_e, w_sl_e;
  logic       w_sel_nxt;
  logic [9:0] w_ry0, w_ry1;
  logic       w_hit;

  assign w_up_e = i_btn_up & ~r_up_q;
  assign w_dn_e = i_btn_down & ~r_dn_q;
  assign w_sl_e = i_btn_select & ~r_sl_q;

  // Simultaneous up/down edges cancel out
  always_comb begin
    w_sel_nxt = r_sel;
    if (w_up_e && !w_dn_e)
      w_sel_nxt = 1'b0;
    else if (w_dn_e && !w_up_e)
      w_sel_nxt = 1'b1;
  end

  assign w_ry0 = r_sel ? RY10 : RY00;
  assign w_ry1 = r_sel ? RY11 : RY01;
  assign w_hit = (i_col >= CX0) && (i_col < CX1) &&
                 (i_row >= w_ry0) && (i_row < w_ry1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_MENU;
      r_sel        <= 1'b0;
      r_two_player <= 1'b0;
      r_rgb        <= 3'b000;
      r_blink_on   <= 1'b1;
      r_blink_cnt  <= '0;
      r_over_cnt   <= '0;
      r_up_q       <= 1'b0;
      r_dn_q       <= 1'b0;
      r_sl_q       <= 1'b0;
    end else begin
      r_up_q <= i_btn_up;
      r_dn_q <= i_btn_down;
      r_sl_q <= i_btn_select;
      case (r_state)
        S_MENU: begin
          r_rgb <= (w_hit && r_blink_on) ? 3'b111 : i_menu_rgb;
          r_sel <= w_sel_nxt;
          // A moved cursor restarts the blink so it is visible immediately
          if (w_sel_nxt != r_sel) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
          end else if (i_frame_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
              r_blink_cnt <= '0;
              r_blink_on  <= ~r_blink_on;
            end else begin
              r_blink_cnt <= r_blink_cnt + 1'b1;
            end
          end
          if (w_sl_e) begin
            r_two_player <= r_sel;
            r_state      <= S_START;
          end
        end
        S_START: begin
          r_rgb   <= i_menu_rgb;
          r_state <= S_GAME;
        end
        S_GAME: begin
          r_rgb <= 3'b000;
          if (i_game_over) begin
            r_over_cnt <= '0;
            r_state    <= S_OVER;
          end
        end
        default: begin
          r_rgb <= i_menu_rgb;
          if (i_frame_tick) begin
            if (r_over_cnt == OVER_LAST) begin
              r_over_cnt  <= '0;
              r_blink_cnt <= '0;
              r_blink_on  <= 1'b1;
              r_state     <= S_MENU;
            end else begin
              r_over_cnt <= r_over_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign o_rgb         = r_rgb;
  assign o_menu_active = (r_state != S_GAME);
  assign o_game_start  = (r_state == S_START);
  assign o_two_player  = r_two_player;

endmodule

// File: tb/tb_menu_controller.sv
// Bench for menu_controller: fixed vector table, directed menu/game sequences,
// then random stimulus scored against a frame-counting behavioural model.
module tb_menu_controller;
  localparam int PX = 234, PY = 214, CXO = 8, O0 = 14, O1 = 34, CS = 8;
  localparam int BF = 30, OF = 120;

  logic       clk = 1'b0;
  logic       rst = 1'b0, up = 1'b0, dn = 1'b0, sl = 1'b0, fr = 1'b0, go = 1'b0;
  logic [9:0] row = '0, col = '0;
  logic [2:0] mrgb = '0;
  logic [2:0] o_rgb;
  logic       o_menu_active, o_game_start, o_two_player;

  always #5 clk = ~clk;

  menu_controller #(
    .MENU_POSX(PX), .MENU_POSY(PY), .CURSOR_X(CXO), .OPT0_Y(O0), .OPT1_Y(O1),
    .CURSOR_SIZE(CS), .BLINK_FRAMES(BF), .OVER_FRAMES(OF)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_frame_tick(fr), .i_btn_up(up),
    .i_btn_down(dn), .i_btn_select(sl), .i_game_over(go), .i_row(row),
    .i_col(col), .i_menu_rgb(mrgb), .o_rgb(o_rgb),
    .o_menu_active(o_menu_active), .o_game_start(o_game_start),
    .o_two_player(o_two_player)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: blink phase derived from frames elapsed since the last restart
  typedef enum int {MD_MENU, MD_LAUNCH, MD_PLAY, MD_GAMEOVER} md_t;
  md_t        m_mode = MD_MENU;
  int         m_sel = 0, m_tp = 0, m_since = 0, m_over = 0;
  logic       m_pu = 1'b0, m_pd = 1'b0, m_ps = 1'b0;
  logic [2:0] m_rgb = '0;

  task automatic model_step();
    bit ue, de, se, hit;
    int ns, ry;
    if (rst) begin
      m_mode = MD_MENU; m_sel = 0; m_tp = 0; m_since = 0; m_over = 0;
      m_pu = 0; m_pd = 0; m_ps = 0; m_rgb = 3'd0;
      return;
    end
    ue = up && !m_pu;
    de = dn && !m_pd;
    se = sl && !m_ps;
    ry = PY + ((m_sel != 0) ? O1 : O0);
    hit = (int'(col) >= PX + CXO) && (int'(col) < PX + CXO + CS) &&
          (int'(row) >= ry) && (int'(row) < ry + CS);
    case (m_mode)
      MD_MENU: m_rgb = (hit && ((m_since / BF) % 2 == 0)) ? 3'd7 : mrgb;
      MD_PLAY: m_rgb = 3'd0;
      default: m_rgb = mrgb;
    endcase
    case (m_mode)
      MD_MENU: begin
        ns = m_sel;
        if (ue && !de) ns = 0;
        else if (de && !ue) ns = 1;
        if (se) begin m_tp = m_sel; m_mode = MD_LAUNCH; end
        if (ns != m_sel) m_since = 0;
        else if (fr) m_since++;
        m_sel = ns;
      end
      MD_LAUNCH: m_mode = MD_PLAY;
      MD_PLAY: if (go) begin m_mode = MD_GAMEOVER; m_over = 0; end
      MD_GAMEOVER: if (fr) begin
        m_over++;
        if (m_over == OF) begin m_mode = MD_MENU; m_since = 0; end
      end
    endcase
    m_pu = up; m_pd = dn; m_ps = sl;
  endtask

  task automatic cyc(input logic r, u, d, s, f, g,
                     input logic [9:0] rw, cl, input logic [2:0] mr);
    @(negedge clk);
    rst = r; up = u; dn = d; sl = s; fr = f; go = g; row = rw; col = cl; mrgb = mr;
    @(posedge clk);
    model_step();
    #1;
    chk("model", {o_rgb, o_menu_active, o_game_start, o_two_player},
        {m_rgb, m_mode != MD_PLAY, m_mode == MD_LAUNCH, m_tp != 0});
  endtask

  task automatic frames(input int n, input logic [9:0] rw, cl, input logic [2:0] mr);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 0, 1, 0, rw, cl, mr);
      cyc(0, 0, 0, 0, 0, 0, rw, cl, mr);
    end
  endtask

  typedef struct {
    logic rst, up, dn, sl, fr, go;
    logic [9:0] row, col;
    logic [2:0] mrgb;
    logic [2:0] e_rgb;
    logic e_ma, e_gs, e_tp;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1,0,0,0,0,0, 10'd228, 10'd242, 3'd3, 3'd0, 1,0,0};
    tbl[1]  = '{0,0,0,0,0,0, 10'd228, 10'd242, 3'd3, 3'd7, 1,0,0};
    tbl[2]  = '{0,0,0,0,0,0, 10'd228, 10'd250, 3'd5, 3'd5, 1,0,0};
    tbl[3]  = '{0,0,0,0,0,0, 10'd227, 10'd242, 3'd2, 3'd2, 1,0,0};
    tbl[4]  = '{0,0,1,0,0,0, 10'd248, 10'd242, 3'd1, 3'd1, 1,0,0};
    tbl[5]  = '{0,0,1,0,0,0, 10'd248, 10'd249, 3'd1, 3'd7, 1,0,0};
    tbl[6]  = '{0,0,0,0,0,0, 10'd255, 10'd242, 3'd4, 3'd7, 1,0,0};
    tbl[7]  = '{0,0,0,0,0,0, 10'd256, 10'd242, 3'd4, 3'd4, 1,0,0};
    tbl[8]  = '{0,0,0,1,0,0, 10'd248, 10'd242, 3'd0, 3'd7, 1,1,1};
    tbl[9]  = '{0,0,0,1,0,0, 10'd248, 10'd242, 3'd6, 3'd6, 0,0,1};
    tbl[10] = '{0,0,0,0,0,0, 10'd248, 10'd242, 3'd5, 3'd0, 0,0,1};
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].rst, tbl[i].up, tbl[i].dn, tbl[i].sl, tbl[i].fr, tbl[i].go,
          tbl[i].row, tbl[i].col, tbl[i].mrgb);
      chk($sformatf("vec%0d", i), {o_rgb, o_menu_active, o_game_start, o_two_player},
          {tbl[i].e_rgb, tbl[i].e_ma, tbl[i].e_gs, tbl[i].e_tp});
    end

    // Game over -> hold with cursor hidden and buttons ignored
    cyc(0, 0, 0, 0, 0, 1, 10'd248, 10'd242, 3'd2);
    chk("over_menu_active", o_menu_active, 1);
    cyc(0, 0, 0, 0, 0, 0, 10'd248, 10'd242, 3'd2);
    chk("over_cursor_hidden", o_rgb, 2);
    cyc(0, 1, 0, 0, 0, 0, 10'd248, 10'd242, 3'd2);
    cyc(0, 0, 0, 0, 0, 0, 10'd248, 10'd242, 3'd2);
    frames(OF - 1, 10'd248, 10'd242, 3'd2);
    cyc(0, 0, 0, 0, 0, 0, 10'd248, 10'd242, 3'd2);
    chk("over_still_held", o_rgb, 2);
    cyc(0, 0, 0, 0, 1, 0, 10'd248, 10'd242, 3'd2);
    cyc(0, 0, 0, 0, 0, 0, 10'd248, 10'd242, 3'd2);
    chk("back_menu_sel1_cursor", o_rgb, 7);
    chk("back_menu_two_player", o_two_player, 1);
    cyc(0, 0, 0, 0, 0, 1, 10'd248, 10'd242, 3'd2);
    chk("menu_ignores_go", {o_menu_active, o_game_start}, 2'b10);

    // Blink half-period
    frames(BF - 1, 10'd248, 10'd242, 3'd3);
    cyc(0, 0, 0, 0, 0, 0, 10'd248, 10'd242, 3'd3);
    chk("blink_before_toggle", o_rgb, 7);
    cyc(0, 0, 0, 0, 1, 0, 10'd248, 10'd242, 3'd3);
    cyc(0, 0, 0, 0, 0, 0, 10'd248, 10'd242, 3'd3);
    chk("blink_off", o_rgb, 3);
    frames(BF - 1, 10'd248, 10'd242, 3'd3);
    cyc(0, 0, 0, 0, 1, 0, 10'd248, 10'd242, 3'd3);
    cyc(0, 0, 0, 0, 0, 0, 10'd248, 10'd242, 3'd3);
    chk("blink_back_on", o_rgb, 7);

    // Held button gives one event; simultaneous up/down edges cancel
    cyc(0, 1, 0, 0, 0, 0, 10'd228, 10'd242, 3'd5);
    cyc(0, 0, 0, 0, 0, 0, 10'd228, 10'd242, 3'd5);
    chk("up_to_opt0", o_rgb, 7);
    frames(20, 10'd228, 10'd242, 3'd5);
    for (int i = 0; i < 100; i++) cyc(0, 0, 1, 0, 0, 0, 10'd248, 10'd242, 3'd5);
    cyc(0, 0, 0, 0, 0, 0, 10'd248, 10'd242, 3'd5);
    cyc(0, 1, 1, 0, 0, 0, 10'd248, 10'd242, 3'd5);
    cyc(0, 0, 0, 0, 0, 0, 10'd248, 10'd242, 3'd5);
    frames(BF - 1, 10'd248, 10'd242, 3'd5);
    cyc(0, 0, 0, 0, 0, 0, 10'd248, 10'd242, 3'd5);
    chk("sel1_blink_restarted", o_rgb, 7);
    cyc(0, 0, 0, 0, 0, 0, 10'd228, 10'd242, 3'd5);
    chk("opt0_not_cursor", o_rgb, 5);

    // Launch with sel=1
    cyc(0, 0, 0, 1, 0, 0, 10'd228, 10'd242, 3'd5);
    chk("start_pulse", {o_game_start, o_two_player}, 2'b11);
    cyc(0, 0, 0, 1, 0, 0, 10'd228, 10'd242, 3'd5);
    chk("start_one_cycle", {o_game_start, o_menu_active}, 2'b00);
    cyc(0, 0, 0, 0, 0, 0, 10'd228, 10'd242, 3'd5);
    chk("game_black", o_rgb, 0);

    // Reset in the middle of the game-over hold
    cyc(0, 0, 0, 0, 0, 1, 10'd228, 10'd242, 3'd5);
    frames(50, 10'd228, 10'd242, 3'd5);
    cyc(1, 0, 0, 0, 1, 0, 10'd228, 10'd242, 3'd5);
    chk("reset_over", {o_menu_active, o_two_player, o_rgb}, 5'b10000);
    frames(3, 10'd228, 10'd242, 3'd1);
    cyc(0, 0, 0, 0, 0, 0, 10'd228, 10'd242, 3'd1);
    chk("reset_cursor_opt0", o_rgb, 7);
    cyc(0, 0, 0, 0, 0, 0, 10'd228, 10'd241, 3'd6);
    chk("reset_outside_pixel", o_rgb, 6);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
          10'(PY + $urandom_range(0, 59)), 10'(PX + $urandom_range(0, 23)),
          3'($urandom_range(0, 7)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/menu_controller.md
Name: menu_controller

Overview:
- Sequences the Pong start menu. Holds the player-mode selection and drives a blinking selection cursor.
- Composites the cursor over the start-menu bitmap pixel, issues a one-cycle game-start pulse, and returns to the menu after a game ends.
- Sits between the VGA timing generator, the start-menu bitmap ROM (combinational row/col -> rgb) and the game logic.

Parameters:
- MENU_POSX, 234, menu bitmap left edge in screen pixels (must match bitmap instance)
- MENU_POSY, 214, menu bitmap top edge in screen pixels
- CURSOR_X, 8, cursor left edge relative to MENU_POSX
- OPT0_Y, 14, cursor top edge relative to MENU_POSY for option 0 (1 player)
- OPT1_Y, 34, cursor top edge relative to MENU_POSY for option 1 (2 players)
- CURSOR_SIZE, 8, cursor square side in pixels
- BLINK_FRAMES, 30, frame ticks per cursor on/off half-period (>=1)
- OVER_FRAMES, 120, frame ticks the game-over hold lasts (>=1)

Ports:
- clk  in  1  system clock (pixel clock domain)
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- btn_up  in  1  level, already synchronized/debounced
- btn_down  in  1  level, already synchronized/debounced
- btn_select  in  1  level, already synchronized/debounced
- game_over  in  1  one-cycle pulse from game logic
- row  in  10  current VGA pixel row
- col  in  10  current VGA pixel column
- menu_rgb  in  3  bitmap pixel for the current row/col (combinational source)
- rgb  out  3  composited pixel, registered
- menu_active  out  1  high while the menu layer owns the screen
- game_start  out  1  one-cycle pulse on game launch
- two_player  out  1  latched mode selection (0 = 1P, 1 = 2P)

Behaviour:
- Reset (synchronous, active-high, overrides all other inputs in that cycle):
  - state=MENU, sel=0, two_player=0, game_start=0, rgb=000, menu_active=1
  - blink_on=1, blink_cnt=0, over_cnt=0, button history registers cleared
- Button edges: a press is detected when the current level is 1 and the previous cycle's level was 0, per button. Holding a button yields exactly one event.
- States:
  - MENU:
    - up edge -> sel=0; down edge -> sel=1 (saturating, no wrap)
    - up and down edges in the same cycle -> no change
    - select edge -> two_player<=sel (pre-update value, if up/down coincide), game_start=1 next cycle, state->START
  - START: lasts one cycle; game_start=1 during it; -> GAME. Buttons ignored.
  - GAME: menu_active=0, rgb=000. Buttons ignored. game_over pulse -> OVER, over_cnt=0.
  - OVER: menu_active=1, bitmap shown, cursor hidden, buttons ignored. over_cnt increments on frame_tick; on the frame_tick where over_cnt==OVER_FRAMES-1 -> MENU. sel and two_player are preserved.
  - game_over seen in any state other than GAME is ignored.
- Blink (active only in MENU):
  - blink_cnt increments on frame_tick; at BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
  - Any sel change, and entry into MENU, forces blink_cnt=0 and blink_on=1.
- Compositing (latency 1 clk, from row/col/menu_rgb to rgb):
  - cursor_hit = col in [MENU_POSX+CURSOR_X, +CURSOR_SIZE) and row in [MENU_POSY+OPTy, +CURSOR_SIZE), where OPTy = OPT0_Y or OPT1_Y by current sel.
  - MENU: rgb<=111 if cursor_hit && blink_on, else menu_rgb
  - OVER and START: rgb<=menu_rgb
  - GAME: rgb<=000
- Arithmetic: all position sums are 10-bit; the parameters must keep every sum below 1024 (no wrap handling).
- Counters are sized to hold BLINK_FRAMES-1 and OVER_FRAMES-1.
- Reset asserted in any state, including START and OVER mid-count, returns to MENU the next cycle with reset values.

Test Plan:
- Reset then idle 3 frames -> state MENU, sel=0, rgb at (row=MENU_POSY+14, col=MENU_POSX+8) = 111 one clk after presentation; pixel outside cursor equals menu_rgb delayed 1 clk.
- Press down held 100 cycles, then up and down both rising same cycle -> sel=1 exactly once, then unchanged; blink_cnt reset to 0 on the change.
- 30 frame_ticks in MENU with sel=1 -> cursor pixel at OPT1_Y becomes menu_rgb; after 30 more it returns to 111.
- select edge with sel=1 -> game_start high exactly 1 cycle, two_player=1, menu_active=0 from GAME entry, rgb=000.
- game_over in GAME -> OVER; cursor hidden, buttons ignored; after 120 frame_ticks -> MENU with sel=1, blink_on=1; game_over in MENU ignored.
- reset asserted during OVER at over_cnt=50 -> next cycle MENU, sel=0, two_player=0, over_cnt=0.
